// File: rtl/frame_ddr_writer_pkg.sv
// Shared constants and state encoding for the frame DDR writer.
package frame_ddr_writer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_DATA = 3'd2,
        ST_RESP = 3'd3,
        ST_DONE = 3'd4
    } wr_state_t;

    localparam int         BURST_BEATS      = 256;
    localparam int         BURST_BYTES      = 1024;
    localparam int         FRAME_BURSTS_DEF = 1025;
    localparam int         RDCOUNT_W        = 11;

    localparam logic [7:0] AXI_LEN          = 8'(BURST_BEATS - 1);
    localparam logic [2:0] AXI_SIZE_4B      = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR   = 2'b01;
    localparam logic [1:0] RESP_OKAY        = 2'b00;

endpackage

// File: rtl/frame_ddr_writer.sv
// Drains a FWFT packet FIFO into a ring of DDR frame slots as 256-beat AXI4 INCR bursts.
// Latency: AW one cycle after 256 words are available; W beats pass FIFO data combinationally.
// Backpressure: awready/wready/bvalid stall the FSM; FIFO is popped only on W handshakes.
module frame_ddr_writer
    import frame_ddr_writer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h8000_0000,
    parameter int          SLOT_NUM     = 4,
    parameter logic [31:0] SLOT_STRIDE  = 32'h0020_0000,
    parameter int          FRAME_BURSTS = FRAME_BURSTS_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,

    input  logic [31:0]          fifo_rddata,
    input  logic                 fifo_empty,
    input  logic [RDCOUNT_W-1:0] fifo_rdcount,
    output logic                 fifo_rden,

    output logic [31:0]          m_axi_awaddr,
    output logic [7:0]           m_axi_awlen,
    output logic [2:0]           m_axi_awsize,
    output logic [1:0]           m_axi_awburst,
    output logic                 m_axi_awvalid,
    input  logic                 m_axi_awready,

    output logic [31:0]          m_axi_wdata,
    output logic [3:0]           m_axi_wstrb,
    output logic                 m_axi_wlast,
    output logic                 m_axi_wvalid,
    input  logic                 m_axi_wready,

    input  logic [1:0]           m_axi_bresp,
    input  logic                 m_axi_bvalid,
    output logic                 m_axi_bready,

    input  logic                 frame_store,
    input  logic [1:0]           frame_type_i,

    output logic                 frame_done,
    output logic [31:0]          frame_addr,
    output logic [1:0]           frame_type_o,
    output logic                 wr_err,
    output logic                 sync_err,
    output logic                 busy
);

    localparam int BC_W = (FRAME_BURSTS > 1) ? $clog2(FRAME_BURSTS) : 1;
    localparam int SI_W = (SLOT_NUM > 1) ? $clog2(SLOT_NUM) : 1;
    localparam logic [BC_W-1:0] LAST_BURST = BC_W'(FRAME_BURSTS - 1);
    localparam logic [SI_W-1:0] LAST_SLOT  = SI_W'(SLOT_NUM - 1);
    localparam logic [7:0]      LAST_BEAT  = 8'(BURST_BEATS - 1);

    wr_state_t       state;
    wr_state_t       state_nxt;
    logic [BC_W-1:0] burst_cnt;
    logic [7:0]      beat_cnt;
    logic [SI_W-1:0] slot_idx;
    logic            store_pending;
    logic [1:0]      type_q;
    logic [31:0]     slot_base;
    logic            w_hs;
    logic            b_hs;
    logic            last_beat;
    logic            last_burst;

    assign slot_base  = BASE_ADDR + 32'(slot_idx) * SLOT_STRIDE;
    assign last_beat  = (beat_cnt == LAST_BEAT);
    assign last_burst = (burst_cnt == LAST_BURST);
    assign w_hs       = m_axi_wvalid & m_axi_wready;
    assign b_hs       = m_axi_bvalid & m_axi_bready;

    assign m_axi_awlen   = AXI_LEN;
    assign m_axi_awsize  = AXI_SIZE_4B;
    assign m_axi_awburst = AXI_BURST_INCR;
    assign m_axi_wstrb   = 4'hF;

    // Address and data are gated to zero outside their phases so every output is quiet in reset.
    assign m_axi_awaddr = (state == ST_ADDR)
                        ? slot_base + 32'(burst_cnt) * 32'(BURST_BYTES) : '0;
    assign m_axi_wdata  = (state == ST_DATA) ? fifo_rddata : '0;
    assign m_axi_wlast  = (state == ST_DATA) && last_beat;
    assign fifo_rden    = w_hs;
    assign frame_done   = (state == ST_DONE);
    assign busy         = (state != ST_IDLE);

    always_comb begin
        state_nxt     = state;
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_bready  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (fifo_rdcount >= RDCOUNT_W'(BURST_BEATS)) state_nxt = ST_ADDR;
            end
            ST_ADDR: begin
                m_axi_awvalid = 1'b1;
                if (m_axi_awready) state_nxt = ST_DATA;
            end
            ST_DATA: begin
                m_axi_wvalid = !fifo_empty;
                if (!fifo_empty && m_axi_wready && last_beat) state_nxt = ST_RESP;
            end
            ST_RESP: begin
                m_axi_bready = 1'b1;
                if (m_axi_bvalid) state_nxt = last_burst ? ST_DONE : ST_IDLE;
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            burst_cnt     <= '0;
            beat_cnt      <= '0;
            slot_idx      <= '0;
            store_pending <= 1'b0;
            type_q        <= '0;
            frame_addr    <= '0;
            frame_type_o  <= '0;
            wr_err        <= 1'b0;
            sync_err      <= 1'b0;
        end else begin
            if (w_hs) beat_cnt <= beat_cnt + 8'd1;
            if (b_hs && !last_burst) burst_cnt <= burst_cnt + 1'b1;
            if (b_hs && (m_axi_bresp != RESP_OKAY)) wr_err <= 1'b1;
            // Report fields are captured on the final B so they are valid during the done pulse.
            if (b_hs && last_burst) begin
                frame_addr   <= slot_base;
                frame_type_o <= frame_store ? frame_type_i : type_q;
                if (!store_pending) sync_err <= 1'b1;
            end
            if (state == ST_DONE) begin
                burst_cnt <= '0;
                slot_idx  <= (slot_idx == LAST_SLOT) ? '0 : slot_idx + 1'b1;
            end
            // A store arriving in the done cycle belongs to the next frame, so it wins.
            if (frame_store) begin
                type_q        <= frame_type_i;
                store_pending <= 1'b1;
            end else if (state == ST_DONE) begin
                store_pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_frame_ddr_writer.sv
// Bench for frame_ddr_writer: FIFO/AXI slave models plus a frame-level reference of addresses, data order and flags.
module tb_frame_ddr_writer;
    import frame_ddr_writer_pkg::*;

    localparam int          NB     = 9;
    localparam int          SLOTS  = 4;
    localparam logic [31:0] BASE   = 32'h8000_0000;
    localparam logic [31:0] STRIDE = 32'h0020_0000;

    logic        clk;
    logic        rst_n;
    logic [31:0] fifo_rddata;
    logic        fifo_empty;
    logic [10:0] fifo_rdcount;
    logic        fifo_rden;
    logic [31:0] m_axi_awaddr;
    logic [7:0]  m_axi_awlen;
    logic [2:0]  m_axi_awsize;
    logic [1:0]  m_axi_awburst;
    logic        m_axi_awvalid;
    logic        m_axi_awready;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wlast;
    logic        m_axi_wvalid;
    logic        m_axi_wready;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_bvalid;
    logic        m_axi_bready;
    logic        frame_store;
    logic [1:0]  frame_type_i;
    logic        frame_done;
    logic [31:0] frame_addr;
    logic [1:0]  frame_type_o;
    logic        wr_err;
    logic        sync_err;
    logic        busy;

    frame_ddr_writer #(
        .BASE_ADDR(BASE), .SLOT_NUM(SLOTS), .SLOT_STRIDE(STRIDE), .FRAME_BURSTS(NB)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .fifo_rddata(fifo_rddata), .fifo_empty(fifo_empty),
        .fifo_rdcount(fifo_rdcount), .fifo_rden(fifo_rden),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
        .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .frame_store(frame_store), .frame_type_i(frame_type_i),
        .frame_done(frame_done), .frame_addr(frame_addr), .frame_type_o(frame_type_o),
        .wr_err(wr_err), .sync_err(sync_err), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            if (miscompares <= 40)
                $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] gen(input int n);
        return (32'(n) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Reference model state: FIFO contents and frame/burst/beat progress.
    logic [31:0] fq[$];
    logic [31:0] done_log[$];
    int   pushed, push_target, wn, frame_idx, burst_idx, beats, frames_done, b_delay, aw_count;
    bit   aw_open, b_wait, pend_m, err_exp, sync_exp, done_due, aw_wait_prev;
    logic [31:0] aw_prev;
    logic [1:0]  type_m, type_done_exp;
    int   rand_mode, err_burst, store_beat;
    bit   store_on_done;

    typedef struct {
        int   count;
        int   hold;
        logic exp_aw;
    } thr_vec_t;
    thr_vec_t thr[6];
    logic [31:0] exp_ring[5];

    task automatic model_reset();
        fq.delete();
        pushed = 0; push_target = 0; wn = 0; frame_idx = 0; burst_idx = 0; beats = 0;
        aw_open = 0; b_wait = 0; b_delay = 0; pend_m = 0; err_exp = 0; sync_exp = 0;
        done_due = 0; aw_wait_prev = 0; aw_prev = 0; type_m = 0; type_done_exp = 0;
        frame_store = 0; frame_type_i = 0; m_axi_bvalid = 0; m_axi_bresp = 0;
        m_axi_awready = 0; m_axi_wready = 0;
        fifo_empty = 1; fifo_rdcount = 0; fifo_rddata = 0;
    endtask

    // One clock: observe at the falling edge, then advance the model and drive just after the rising edge.
    task automatic cycle();
        logic aw_hs, w_hs, b_hs, rden_s, fs_s, last_b;
        @(negedge clk);
        aw_hs  = m_axi_awvalid & m_axi_awready;
        w_hs   = m_axi_wvalid & m_axi_wready;
        b_hs   = m_axi_bvalid & m_axi_bready;
        rden_s = fifo_rden;
        if (m_axi_wvalid || (aw_open && fq.size() > 0))
            chk("wvalid", m_axi_wvalid, aw_open && fq.size() > 0);
        if (fifo_rden || w_hs) chk("fifo_rden", fifo_rden, w_hs);
        if (m_axi_awvalid) chk("aw_single_outstanding", aw_open || b_wait, 0);
        if (m_axi_bready) chk("bready_after_burst", b_wait, 1);
        if (aw_wait_prev) begin
            chk("awvalid_held", m_axi_awvalid, 1);
            chk("awaddr_held", m_axi_awaddr, aw_prev);
        end
        aw_wait_prev = m_axi_awvalid && !m_axi_awready;
        aw_prev      = m_axi_awaddr;
        if (aw_hs) begin
            chk("aw_threshold", fifo_rdcount >= 11'd256, 1);
            chk("awaddr", m_axi_awaddr,
                BASE + 32'(frame_idx % SLOTS) * STRIDE + 32'(burst_idx) * 32'd1024);
        end
        if (w_hs) begin
            chk("w_after_aw", aw_open, 1);
            chk("wdata", m_axi_wdata, gen(wn));
            chk("wlast", m_axi_wlast, beats == 255);
        end
        if (frame_done) done_log.push_back(frame_addr);
        if (frame_done || done_due) begin
            chk("frame_done", frame_done, done_due);
            if (done_due) begin
                chk("frame_addr", frame_addr, BASE + 32'(frame_idx % SLOTS) * STRIDE);
                chk("frame_type", frame_type_o, type_done_exp);
                chk("wr_err", wr_err, err_exp);
                chk("sync_err", sync_err, sync_exp);
            end
        end
        last_b = b_hs && (burst_idx == NB - 1);

        @(posedge clk);
        #1;
        fs_s = frame_store;
        if (rden_s && fq.size() > 0) void'(fq.pop_front());
        if (aw_hs) begin
            aw_open = 1; beats = 0; aw_count++;
        end
        if (w_hs) begin
            beats++; wn++;
            if (beats == 256) begin
                aw_open = 0; b_wait = 1;
                b_delay = (rand_mode != 0) ? int'($urandom_range(3, 0)) : 0;
            end
        end
        if (b_hs) begin
            b_wait = 0;
            if (m_axi_bresp != 2'b00) err_exp = 1;
            if (last_b && !pend_m) sync_exp = 1;
            burst_idx++;
        end
        if (done_due) begin
            frame_idx++; burst_idx = 0; frames_done++;
            pend_m = fs_s;
        end else if (fs_s) begin
            pend_m = 1;
        end
        if (fs_s) type_m = frame_type_i;
        if (last_b) type_done_exp = type_m;
        done_due = last_b;

        frame_store  = 0;
        if (store_beat >= 0 && w_hs && burst_idx == store_beat / 256 && beats == store_beat % 256)
            frame_store = 1;
        if (store_on_done && last_b) frame_store = 1;
        frame_type_i = 2'($urandom_range(3, 0));

        if (pushed < push_target && fq.size() < 2000 &&
            (rand_mode == 0 || $urandom_range(7, 0) < 3)) begin
            fq.push_back(gen(pushed));
            pushed++;
        end
        fifo_empty   = (fq.size() == 0);
        fifo_rddata  = fifo_empty ? $urandom : fq[0];
        fifo_rdcount = (fq.size() > 2047) ? 11'd2047 : 11'(fq.size());
        m_axi_awready = (rand_mode != 0) ? 1'($urandom_range(1, 0)) : 1'b1;
        m_axi_wready  = (rand_mode != 0) ? 1'($urandom_range(1, 0)) : 1'b1;
        if (b_wait) begin
            if (b_delay > 0) begin
                b_delay--; m_axi_bvalid = 0;
            end else begin
                m_axi_bvalid = 1;
            end
        end else begin
            m_axi_bvalid = 0;
        end
        m_axi_bresp = (burst_idx == err_burst) ? 2'b10 : 2'b00;
    endtask

    task automatic run_frames(input int n, input int budget, input string tag);
        int target;
        int cyc;
        target = frames_done + n;
        cyc = 0;
        push_target += n * NB * 256;
        while (frames_done < target && cyc < budget) begin
            cycle();
            cyc++;
        end
        chk(tag, frames_done, target);
    endtask

    initial begin
        thr = '{'{0, 4, 1'b0}, '{1, 4, 1'b0}, '{128, 4, 1'b0},
                '{255, 30, 1'b0}, '{256, 2, 1'b1}, '{2047, 2, 1'b1}};
        exp_ring = '{32'h8000_0000, 32'h8020_0000, 32'h8040_0000, 32'h8060_0000, 32'h8000_0000};
        frames_done = 0; aw_count = 0;
        rand_mode = 0; err_burst = -1; store_beat = -1; store_on_done = 0;
        rst_n = 0;
        model_reset();
        fifo_empty = 0; fifo_rdcount = 11'd300; fifo_rddata = 32'hDEAD_BEEF;
        m_axi_awready = 1; m_axi_wready = 1; m_axi_bvalid = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ctrl", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, fifo_rden,
                         frame_done, wr_err, sync_err, busy}, 0);
        chk("rst_frame_addr", frame_addr, 0);
        chk("rst_frame_type", frame_type_o, 0);
        chk("awlen", m_axi_awlen, 255);
        chk("awsize", m_axi_awsize, 3'b010);
        chk("awburst", m_axi_awburst, 2'b01);
        chk("wstrb", m_axi_wstrb, 4'hF);

        m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0;
        for (int i = 0; i < 6; i++) begin
            rst_n = 0;
            fifo_rdcount = 11'(thr[i].count);
            fifo_empty   = (thr[i].count == 0);
            @(posedge clk);
            #1 rst_n = 1;
            for (int c = 0; c < thr[i].hold; c++) begin
                @(negedge clk);
                if (!thr[i].exp_aw) chk($sformatf("thr_idle_%0d", thr[i].count), m_axi_awvalid, 0);
            end
            chk($sformatf("thr_aw_%0d", thr[i].count), m_axi_awvalid, thr[i].exp_aw);
            chk($sformatf("thr_busy_%0d", thr[i].count), busy, thr[i].exp_aw);
            if (thr[i].exp_aw) chk("thr_awaddr", m_axi_awaddr, BASE);
        end

        rst_n = 0;
        fifo_rdcount = 11'd255; fifo_empty = 0;
        @(posedge clk);
        #1 rst_n = 1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("hold_255", m_axi_awvalid, 0);
        end
        @(posedge clk);
        #1 fifo_rdcount = 11'd256;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            if (m_axi_awvalid) break;
        end
        chk("rise_256_aw", m_axi_awvalid, 1);

        rst_n = 0;
        model_reset();
        @(posedge clk);
        #1 rst_n = 1;

        rand_mode = 0; store_beat = 1000;
        done_log.delete(); aw_count = 0;
        run_frames(5, 20000, "ring_frames");
        chk("ring_done_cnt", done_log.size(), 5);
        for (int i = 0; i < 5; i++)
            if (i < done_log.size()) chk($sformatf("ring_addr_%0d", i), done_log[i], exp_ring[i]);
        chk("ring_aw_cnt", aw_count, 5 * NB);

        rand_mode = 1; store_beat = 500; store_on_done = 1;
        run_frames(1, 20000, "random_frame");

        rand_mode = 0; store_beat = -1; store_on_done = 0; err_burst = 7; aw_count = 0;
        run_frames(1, 6000, "slverr_frame");
        chk("slverr_aw_cnt", aw_count, NB);
        chk("slverr_sticky", wr_err, 1);
        chk("slverr_no_sync", sync_err, 0);
        err_burst = -1;

        run_frames(1, 6000, "nostore_frame");
        chk("nostore_sync", sync_err, 1);
        chk("nostore_wr_err", wr_err, 1);

        push_target += NB * 256;
        for (int c = 0; c < 3000; c++) begin
            if (aw_open && beats == 100) break;
            cycle();
        end
        chk("reach_beat_100", beats, 100);
        #2 rst_n = 0;
        #1;
        chk("arst_awvalid", m_axi_awvalid, 0);
        chk("arst_wvalid", m_axi_wvalid, 0);
        chk("arst_rden", fifo_rden, 0);
        chk("arst_busy", busy, 0);
        chk("arst_flags", {wr_err, sync_err}, 0);
        model_reset();
        frame_idx = 0;
        @(posedge clk);
        #1 rst_n = 1;

        store_beat = 1000; done_log.delete();
        run_frames(1, 6000, "post_reset_frame");
        if (done_log.size() > 0) chk("post_reset_addr", done_log[0], BASE);
        chk("post_reset_flags", {wr_err, sync_err}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/frame_ddr_writer.md
FRAME_DDR_WRITER -- requirements
Module: frame_ddr_writer

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h8000_0000, meaning byte address of frame slot 0.
REQ-002 SHALL have parameter SLOT_NUM, default 4, meaning number of ring frame slots in DDR.
REQ-003 SHALL have parameter SLOT_STRIDE, default 32'h0020_0000, meaning byte distance between slots.
REQ-004 SHALL have parameter FRAME_BURSTS, default 1025, meaning bursts per frame (262144 pixel words + 256 trailer words).
REQ-005 SHALL have port clk, input, 1, meaning the single clock.
REQ-006 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-007 SHALL have ports fifo_rddata in 32, fifo_empty in 1, fifo_rdcount in 11, fifo_rden out 1, meaning the FWFT read side of the packet FIFO.
REQ-008 SHALL have AXI4 write-master ports m_axi_aw* (addr 32, len 8, size 3, burst 2, valid, ready), m_axi_w* (data 32, strb 4, last, valid, ready), m_axi_b* (resp 2, valid, ready).
REQ-009 SHALL have ports frame_store in 1 and frame_type_i in 2, meaning the packer's end-of-frame pulse and frame type.
REQ-010 SHALL have outputs frame_done 1, frame_addr 32, frame_type_o 2, wr_err 1, sync_err 1, busy 1.

Function
REQ-011 SHALL drive constant awlen=255, awsize=3'b010, awburst=INCR, wstrb=4'hF.
REQ-012 SHALL implement states IDLE, ADDR, DATA, RESP, DONE.
REQ-013 IDLE->ADDR when fifo_rdcount>=256; otherwise stay; no AW issued below 256 words.
REQ-014 ADDR: awvalid=1, awaddr=slot_base+burst_cnt*1024, held stable until awready; ->DATA on handshake.
REQ-015 DATA: wvalid=!fifo_empty, wdata=fifo_rddata, fifo_rden=wvalid&wready; beat counter (8 bit) increments per W handshake.
REQ-016 wlast SHALL be 1 exactly on beat 255; after the last handshake ->RESP.
REQ-017 RESP: bready=1; on bvalid, if burst_cnt==FRAME_BURSTS-1 ->DONE, else burst_cnt+1 and ->IDLE.
REQ-018 Any bresp!=OKAY SHALL set wr_err (sticky until reset); the frame continues unaffected.
REQ-019 DONE (one cycle): frame_done=1 for one cycle, frame_addr=current slot_base, frame_type_o=latched type; burst_cnt->0; slot index+1, wrapping SLOT_NUM-1->0; ->IDLE.
REQ-020 frame_store pulse SHALL latch frame_type_i and set store_pending; DONE clears store_pending.
REQ-021 Entering DONE with store_pending=0 SHALL set sticky sync_err.
REQ-022 frame_store coinciding with DONE SHALL be kept pending (latch wins over clear).
REQ-023 Exactly one outstanding AXI transaction; no W beat before AW handshake.
REQ-024 busy=1 in any state except IDLE.
REQ-025 slot_base=BASE_ADDR+slot_idx*SLOT_STRIDE; bursts are 1 KiB aligned and never cross 4 KiB.

Reset
REQ-026 rst_n low SHALL asynchronously force state IDLE, burst_cnt 0, beat 0, slot_idx 0, store_pending 0.
REQ-027 All outputs SHALL reset to 0 (awvalid, wvalid, bready, fifo_rden, frame_done, frame_addr, frame_type_o, wr_err, sync_err, busy).
REQ-028 Reset mid-burst SHALL abandon the burst; FIFO flush is not this block's duty.

Structure
REQ-029 State encoding, AXI constants (BURST_BEATS=256, BURST_BYTES=1024, RESP_OKAY) and FRAME_BURSTS default SHALL live in a shared package.
REQ-030 SHALL be one flat module; no sub-module is required.

Verification
REQ-031 Single frame, awready/wready/bvalid immediate, 262400 words -> 1025 bursts, awaddr 0x8000_0000..0x8010_0000 step 0x400, one frame_done, frame_addr=0x8000_0000.
REQ-032 wready random 50%, fifo_empty toggling -> wdata order identical to FIFO order, wlast on every 256th beat only.
REQ-033 fifo_rdcount=255 held -> awvalid stays 0; rdcount->256 -> awvalid=1 within 2 cycles.
REQ-034 Five frames with frame_store each -> frame_addr 0x8000_0000, 0x8020_0000, 0x8040_0000, 0x8060_0000, 0x8000_0000.
REQ-035 bresp=SLVERR on burst 7 -> wr_err=1 and stays; remaining 1017 bursts still issued; frame_done still pulses.
REQ-036 rst_n low during DATA beat 100 -> awvalid/wvalid/fifo_rden 0 without a clock edge; after release next frame starts at burst 0, slot 0.
